mu0_seq_alu: RTL and testbench
==============================

# mu0_seq_alu

Parametrised, registered ALU for the MU0 datapath, generalising the combinational 16-bit ALU to any `WIDTH`. It adds a start/done handshake, result flags, extra logic/shift codes and an iterative shift-add multiplier. It sits between the accumulator/memory-data operands and the ACC write-back path. The control FSM stalls on `busy` instead of assuming single-cycle results.

## Interface
- `WIDTH`, 16, operand/result width (≥4)
- `FS_W`, 4, function-select width
- `clk` in 1, rising-edge clock
- `rst_n` in 1, synchronous active-low reset
- `start` in 1, request; accepted only when `busy`=0
- `fs` in `FS_W`, function code, sampled with `start`
- `a` in `WIDTH`, operand A (ACC), sampled with `start`
- `b` in `WIDTH`, operand B (memory data), sampled with `start`
- `busy` out 1, multi-cycle operation in progress
- `done` out 1, one-cycle pulse: `result`/flags updated this cycle
- `result` out `WIDTH`, registered result, held until next completion
- `flag_z` out 1, `result`==0
- `flag_n` out 1, `result[WIDTH-1]`
- `flag_c` out 1, carry/borrow (see Operation)

## Operation
- Function codes: 0 ZERO, 1 A+B, 2 A−B, 3 B, 4 B+1, 5 A+1, 6 A−1, 7 A*B (low WIDTH bits), 8 A>>1 logical, 9 A<<1, 10 A&B, 11 A|B, 12 A^B, 13 A>>>1 arithmetic. Codes 14–15 give result 0.
- All arithmetic is modulo 2^WIDTH on unsigned operands.
- `flag_c`:
  - ADD, B+1, A+1: carry-out.
  - SUB: borrow, 1 when A<B unsigned.
  - A−1: 1 when A==0.
  - 8, 13: bit shifted out (A[0]).
  - 9: A[WIDTH-1].
  - All other codes: 0.
- FSM states:
  - IDLE: `start` & code≠7 → compute, register `result`/flags, pulse `done`, stay in IDLE. `start` & code 7 → latch A, B; clear product; counter←WIDTH−1; go to MUL.
  - MUL: each cycle, if multiplier LSB is 1, add the shifted multiplicand to the product; then shift multiplicand left and multiplier right. When counter==0 → register `result`/flags, pulse `done`, go to IDLE. Otherwise decrement counter.
- `start` while `busy`=1 is ignored with no side effect.
- `done` pulses for every accepted `start`, including codes 0 and 14–15.

## Timing
- Reset (`rst_n`=0 at an edge): `result`=0, `flag_z`=1, `flag_n`=0, `flag_c`=0, `busy`=0, `done`=0, FSM→IDLE.
- Reset during MUL aborts the operation with no `done` pulse.
- Single-cycle ops: `start` sampled at edge k; `done`=1 and new `result` visible in cycle k+1 (latency 1). Back-to-back `start` on consecutive cycles is allowed, giving 1 result per cycle.
- MUL: `start` sampled at edge k; `busy`=1 in cycles k+1..k+WIDTH; `done`=1 and `result` valid in cycle k+WIDTH (the last busy cycle). `busy`=0 from cycle k+WIDTH+1.
- A new `start` is accepted at edge k+WIDTH+1 at the earliest.
- `a`, `b`, `fs` may change freely after the sampling edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `mu0_alu_pkg`: function-code localparams (`FS_ZERO`…`FS_ASR`), FSM state enum (IDLE, MUL), `FS_W`.
- Sub-module `mu0_shift_add_mul` (parametrised by `WIDTH`): holds the iteration registers and counter, with its own start/done. It is instantiated by `mu0_seq_alu`, which owns the single-cycle datapath, flags and output registers.

## Test plan
- Reset: hold `rst_n`=0 two cycles mid-MUL → `result`=0, `flag_z`=1, `busy`=0, no `done` pulse; next `start` works normally.
- ADD/SUB carry: A=0xFFFF, B=0x0001, fs=1 → `result`=0x0000, Z=1, C=1, `done` next cycle. Then fs=2 with A=0x0001, B=0x0002 → 0xFFFF, N=1, C=1.
- Back-to-back: `start` held 4 cycles with fs=5,6,8,13 on A=0x8001 → results 0x8002, 0x8000, 0x4000 (C=1), 0xC000 (C=1) on 4 consecutive cycles.
- MUL at WIDTH=16: A=0x0123, B=0x0045 → `busy` high exactly 16 cycles, `done` in the 16th, `result`=0x4E6F. A=0xFFFF, B=0xFFFF → 0x0001.
- Busy rejection: `start` with fs=1 during MUL → ignored; only the MUL `done` occurs, and MUL result is unchanged.
- Parametrisation: WIDTH=8, A=0x0F, B=0x11, fs=7 → `result`=0xFF after 8 busy cycles. fs=15 → `result`=0, Z=1, `done` pulses.

Source files
------------

// File: rtl/mu0_alu_pkg.sv
// Shared definitions for the MU0 sequential ALU: function codes and control states.
package mu0_alu_pkg;

  localparam int unsigned FS_W = 4;

  localparam logic [3:0] FS_ZERO = 4'd0;
  localparam logic [3:0] FS_ADD  = 4'd1;
  localparam logic [3:0] FS_SUB  = 4'd2;
  localparam logic [3:0] FS_B    = 4'd3;
  localparam logic [3:0] FS_INCB = 4'd4;
  localparam logic [3:0] FS_INCA = 4'd5;
  localparam logic [3:0] FS_DECA = 4'd6;
  localparam logic [3:0] FS_MUL  = 4'd7;
  localparam logic [3:0] FS_LSR  = 4'd8;
  localparam logic [3:0] FS_LSL  = 4'd9;
  localparam logic [3:0] FS_AND  = 4'd10;
  localparam logic [3:0] FS_OR   = 4'd11;
  localparam logic [3:0] FS_XOR  = 4'd12;
  localparam logic [3:0] FS_ASR  = 4'd13;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } alu_state_e;

endpackage

// File: rtl/mu0_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits of A*B kept.
module mu0_shift_add_mul #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_prod;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_prod_nxt;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_prod_nxt = r_prod + w_addend;

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = w_prod_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      // Bit 0 of B is consumed on the start edge so the final partial product
      // is ready in the last busy cycle.
      r_prod   <= i_b[0] ? i_a : '0;
      r_mcand  <= i_a << 1;
      r_mplier <= i_b >> 1;
      r_cnt    <= CntW'(WIDTH - 2);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mu0_seq_alu.sv
// Registered MU0 ALU: single-cycle ops decoded here, multiply delegated to the shift-add unit.
module mu0_seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FS_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [FS_W-1:0]  i_fs,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_flag_z,
  output logic             o_flag_n,
  output logic             o_flag_c
);

  import mu0_alu_pkg::*;

  localparam logic [WIDTH-1:0] OneW = WIDTH'(1);
  localparam logic [WIDTH:0]   OneX = (WIDTH + 1)'(1);

  alu_state_e       r_state;
  alu_state_e       w_state_d;

  logic             w_hi_zero;
  logic [3:0]       w_code;
  logic             w_accept;
  logic             w_alu_load;
  logic             w_mul_start;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_incb;
  logic [WIDTH:0]   w_inca;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic [WIDTH-1:0] w_new_res;
  logic             w_new_c;

  logic [WIDTH-1:0] r_result;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_flag_c;
  logic             r_busy;
  logic             r_done;

  // Codes beyond the 4-bit range behave like the reserved zero codes.
  assign w_hi_zero = (i_fs >> 4) == '0;
  assign w_code    = w_hi_zero ? i_fs[3:0] : 4'hF;
  assign w_accept  = i_start && !r_busy;

  assign w_add  = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub  = {1'b0, i_a} - {1'b0, i_b};
  assign w_incb = {1'b0, i_b} + OneX;
  assign w_inca = {1'b0, i_a} + OneX;

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    case (w_code)
      FS_ADD:  begin w_alu_res = w_add[WIDTH-1:0];  w_alu_c = w_add[WIDTH];  end
      FS_SUB:  begin w_alu_res = w_sub[WIDTH-1:0];  w_alu_c = w_sub[WIDTH];  end
      FS_B:    w_alu_res = i_b;
      FS_INCB: begin w_alu_res = w_incb[WIDTH-1:0]; w_alu_c = w_incb[WIDTH]; end
      FS_INCA: begin w_alu_res = w_inca[WIDTH-1:0]; w_alu_c = w_inca[WIDTH]; end
      FS_DECA: begin w_alu_res = i_a - OneW;        w_alu_c = (i_a == '0);   end
      FS_LSR:  begin w_alu_res = {1'b0, i_a[WIDTH-1:1]};       w_alu_c = i_a[0];       end
      FS_LSL:  begin w_alu_res = {i_a[WIDTH-2:0], 1'b0};       w_alu_c = i_a[WIDTH-1]; end
      FS_AND:  w_alu_res = i_a & i_b;
      FS_OR:   w_alu_res = i_a | i_b;
      FS_XOR:  w_alu_res = i_a ^ i_b;
      FS_ASR:  begin w_alu_res = {i_a[WIDTH-1], i_a[WIDTH-1:1]}; w_alu_c = i_a[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_alu_load  = 1'b0;
    w_mul_start = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_code == FS_MUL) begin
            w_mul_start = 1'b1;
            w_state_d   = StMul;
          end else begin
            w_alu_load = 1'b1;
          end
        end
      end
      StMul: begin
        if (w_mul_done || !w_mul_busy) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  mu0_shift_add_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (w_mul_start),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_product(w_mul_product)
  );

  assign w_new_res = w_alu_load ? w_alu_res : w_mul_product;
  assign w_new_c   = w_alu_load ? w_alu_c : 1'b0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_flag_z <= 1'b1;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_alu_load || w_mul_done;
      // Busy stays high through the multiply's done cycle; a new start waits one more cycle.
      r_busy <= (w_state_d == StMul) || w_mul_done;
      if (w_alu_load || w_mul_done) begin
        r_result <= w_new_res;
        r_flag_z <= (w_new_res == '0);
        r_flag_n <= w_new_res[WIDTH-1];
        r_flag_c <= w_new_c;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_flag_z = r_flag_z;
  assign o_flag_n = r_flag_n;
  assign o_flag_c = r_flag_c;

endmodule

// File: tb/tb_mu0_seq_alu.sv
// Bench for mu0_seq_alu: 16-bit and 8-bit instances, each scored against a queue of expected results.
module tb_mu0_seq_alu;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start16, busy16, done16, z16, n16, c16;
  logic [3:0]  fs16;
  logic [15:0] a16, b16, res16;
  logic        start8, busy8, done8, z8, n8, c8;
  logic [3:0]  fs8;
  logic [7:0]  a8, b8, res8;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done16 = 0;
  exp_t q16[$];
  exp_t q8[$];

  mu0_seq_alu #(.WIDTH(16), .FS_W(4)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_fs(fs16), .i_a(a16), .i_b(b16),
    .o_busy(busy16), .o_done(done16), .o_result(res16),
    .o_flag_z(z16), .o_flag_n(n16), .o_flag_c(c16)
  );

  mu0_seq_alu #(.WIDTH(8), .FS_W(4)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_fs(fs8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_result(res8),
    .o_flag_z(z8), .o_flag_n(n8), .o_flag_c(c8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model16(input logic [3:0] fs, input logic [15:0] a,
                                   input logic [15:0] b);
    exp_t            e;
    int unsigned     s;
    longint unsigned p;
    e = '0;
    s = 0;
    p = 0;
    case (fs)
      4'd1:  begin s = 32'(a) + 32'(b); e.res = s[15:0]; e.c = s[16]; end
      4'd2:  begin e.res = a - b; e.c = (a < b); end
      4'd3:  e.res = b;
      4'd4:  begin s = 32'(b) + 1; e.res = s[15:0]; e.c = s[16]; end
      4'd5:  begin s = 32'(a) + 1; e.res = s[15:0]; e.c = s[16]; end
      4'd6:  begin e.res = a - 16'd1; e.c = (a == 16'd0); end
      4'd7:  begin p = 64'(a) * 64'(b); e.res = p[15:0]; end
      4'd8:  begin e.res = a >> 1; e.c = a[0]; end
      4'd9:  begin e.res = a << 1; e.c = a[15]; end
      4'd10: e.res = a & b;
      4'd11: e.res = a | b;
      4'd12: e.res = a ^ b;
      4'd13: begin e.res = 16'($signed(a) >>> 1); e.c = a[0]; end
      default: ;
    endcase
    e.z = (e.res == 16'd0);
    e.n = e.res[15];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done16) begin
      n_done16++;
      check_eq("done16_expected", 32'(q16.size() != 0), 32'(1));
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check_eq("result16", 32'(res16), 32'(e.res));
        check_eq("flags16_znc", 32'({z16, n16, c16}), 32'({e.z, e.n, e.c}));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      check_eq("done8_expected", 32'(q8.size() != 0), 32'(1));
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check_eq("result8", 32'(res8), 32'(e.res));
        check_eq("flags8_znc", 32'({z8, n8, c8}), 32'({e.z, e.n, e.c}));
      end
    end
  end

  task automatic issue16(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                         input exp_t e);
    @(negedge clk);
    start16 = 1'b1;
    fs16    = fs;
    a16     = a;
    b16     = b;
    q16.push_back(e);
  endtask

  task automatic idle16();
    @(negedge clk);
    start16 = 1'b0;
    fs16    = 4'($urandom_range(15));
    a16     = 16'($urandom);
    b16     = 16'($urandom);
  endtask

  task automatic run_mul16(input logic [15:0] a, input logic [15:0] b, input exp_t e,
                           input bit inject, input string tag);
    int nb, nd, dcyc;
    nb = 0;
    nd = 0;
    dcyc = 0;
    issue16(4'd7, a, b, e);
    idle16();
    for (int i = 1; i <= 19; i++) begin
      if (busy16) nb++;
      if (done16) begin nd++; dcyc = i; end
      // Stray requests mid-multiply and in the done cycle must be dropped.
      if (inject && (i == 5 || i == 16)) begin
        start16 = 1'b1; fs16 = 4'd1; a16 = 16'h0001; b16 = 16'h0001;
      end else begin
        start16 = 1'b0;
      end
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, 32'(nb), 32'(16));
    check_eq({tag, "_done_cycle"}, 32'(dcyc), 32'(16));
    check_eq({tag, "_done_count"}, 32'(nd), 32'(1));
  endtask

  initial begin
    logic [3:0]  fs;
    logic [15:0] ra, rb;
    int          run, d0, nb, nd, dcyc;

    rst_n = 1'b0;
    start16 = 1'b0; fs16 = '0; a16 = '0; b16 = '0;
    start8  = 1'b0; fs8  = '0; a8  = '0; b8  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_result16", 32'(res16), 32'(0));
    check_eq("rst_znc16", 32'({z16, n16, c16}), 32'(3'b100));
    check_eq("rst_busy16", 32'(busy16), 32'(0));
    check_eq("rst_done16", 32'(done16), 32'(0));
    check_eq("rst_result8", 32'(res8), 32'(0));
    check_eq("rst_znc8", 32'({z8, n8, c8}), 32'(3'b100));
    rst_n = 1'b1;

    issue16(4'd1, 16'hFFFF, 16'h0001, exp_t'{16'h0000, 1'b1, 1'b0, 1'b1});
    idle16();
    check_eq("add_done_latency", 32'(done16), 32'(1));
    issue16(4'd2, 16'h0001, 16'h0002, exp_t'{16'hFFFF, 1'b0, 1'b1, 1'b1});
    idle16();

    run = 0;
    issue16(4'd5, 16'h8001, 16'h1234, exp_t'{16'h8002, 1'b0, 1'b1, 1'b0});
    issue16(4'd6, 16'h8001, 16'h5678, exp_t'{16'h8000, 1'b0, 1'b1, 1'b0});
    if (done16) run++;
    issue16(4'd8, 16'h8001, 16'h9ABC, exp_t'{16'h4000, 1'b0, 1'b0, 1'b1});
    if (done16) run++;
    issue16(4'd13, 16'h8001, 16'hDEF0, exp_t'{16'hC000, 1'b0, 1'b1, 1'b1});
    if (done16) run++;
    idle16();
    if (done16) run++;
    check_eq("b2b_done_run", 32'(run), 32'(4));
    @(negedge clk);
    check_eq("b2b_done_drop", 32'(done16), 32'(0));

    run_mul16(16'h0123, 16'h0045, exp_t'{16'h4E6F, 1'b0, 1'b0, 1'b0}, 1'b0, "mul_a");
    run_mul16(16'hFFFF, 16'hFFFF, exp_t'{16'h0001, 1'b0, 1'b0, 1'b0}, 1'b1, "mul_b");
    ra = 16'($urandom);
    rb = 16'($urandom);
    run_mul16(ra, rb, model16(4'd7, ra, rb), 1'b0, "mul_rand");

    // Abort a multiply with reset; its result must never appear.
    d0 = n_done16;
    @(negedge clk);
    start16 = 1'b1; fs16 = 4'd7; a16 = 16'h00FF; b16 = 16'h0101;
    @(negedge clk);
    start16 = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midmul_busy", 32'(busy16), 32'(1));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_result", 32'(res16), 32'(0));
    check_eq("midrst_znc", 32'({z16, n16, c16}), 32'(3'b100));
    check_eq("midrst_busy", 32'(busy16), 32'(0));
    check_eq("midrst_done", 32'(done16), 32'(0));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("abort_no_done", 32'(n_done16 - d0), 32'(0));
    issue16(4'd1, 16'h0002, 16'h0003, exp_t'{16'h0005, 1'b0, 1'b0, 1'b0});
    idle16();
    check_eq("post_rst_done", 32'(done16), 32'(1));

    for (int i = 0; i < 10; i++) begin
      fs = 4'($urandom_range(15));
      if (fs == 4'd7) fs = 4'd12;
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue16(fs, ra, rb, model16(fs, ra, rb));
    end
    idle16();

    @(negedge clk);
    start8 = 1'b1; fs8 = 4'd7; a8 = 8'h0F; b8 = 8'h11;
    q8.push_back(exp_t'{16'h00FF, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h5C; b8 = 8'hC3;
    nb = 0; nd = 0; dcyc = 0;
    for (int i = 1; i <= 11; i++) begin
      if (busy8) nb++;
      if (done8) begin nd++; dcyc = i; end
      @(negedge clk);
    end
    check_eq("w8_busy_cycles", 32'(nb), 32'(8));
    check_eq("w8_done_cycle", 32'(dcyc), 32'(8));
    check_eq("w8_done_count", 32'(nd), 32'(1));
    start8 = 1'b1; fs8 = 4'd15; a8 = 8'hA5; b8 = 8'h5A;
    q8.push_back(exp_t'{16'h0000, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    start8 = 1'b0;
    check_eq("w8_zero_done", 32'(done8), 32'(1));

    repeat (3) @(negedge clk);
    check_eq("q16_drained", 32'(q16.size()), 32'(0));
    check_eq("q8_drained", 32'(q8.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
